// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared state, opcode, immediate, ALU and writeback encodings for the multi-cycle controller
package mcpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;
    localparam logic [1:0] MTR_IMM = 2'd3;

    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_JAL  = 2'd1;
    localparam logic [1:0] JMP_JALR = 2'd2;

    function automatic logic is_shift(input logic [2:0] fun3);
        return fun3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/mcpu_decode.sv
// mcpu_decode: combinational RV32I opcode/fun3/fun7 decode into datapath controls and instruction class
module mcpu_decode
    import mcpu_pkg::*;
(
    input  logic [31:0] inst,
    output logic [2:0]  imm_sel,
    output logic        alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  mem_to_reg,
    output logic        branch,
    output logic        branch_n,
    output logic [1:0]  jump,
    output iclass_t     iclass,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] fun3;
    logic       fun7b;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign fun3        = inst[14:12];
    assign fun7b       = inst[30];
    assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

    // Branch polarity: odd fun3 (bne/bge/bgeu) selects on the inverted ALU condition.
    assign branch   = iclass == CL_BRANCH && !fun3[0];
    assign branch_n = iclass == CL_BRANCH && fun3[0];
    assign jump     = iclass == CL_JAL ? JMP_JAL : iclass == CL_JALR ? JMP_JALR : JMP_NONE;

    always_comb begin
        imm_sel    = IMM_I;
        alu_src_b  = 1'b1;
        alu_ctrl   = ALU_ADD;
        mem_to_reg = MTR_ALU;
        iclass     = CL_ALU;
        illegal    = 1'b0;
        case (opcode)
            OP_R: begin
                alu_src_b = 1'b0;
                alu_ctrl  = {fun7b, fun3};
            end
            OP_I:      alu_ctrl = {is_shift(fun3) & fun7b, fun3};
            OP_LOAD: begin
                mem_to_reg = MTR_MEM;
                iclass     = CL_LOAD;
            end
            OP_STORE: begin
                imm_sel = IMM_S;
                iclass  = CL_STORE;
            end
            OP_BRANCH: begin
                imm_sel   = IMM_B;
                alu_src_b = 1'b0;
                alu_ctrl  = ALU_SUB;
                iclass    = CL_BRANCH;
            end
            OP_JAL: begin
                imm_sel    = IMM_J;
                mem_to_reg = MTR_PC4;
                iclass     = CL_JAL;
            end
            OP_JALR: begin
                mem_to_reg = MTR_PC4;
                iclass     = CL_JALR;
            end
            OP_LUI: begin
                imm_sel    = IMM_U;
                alu_ctrl   = ALU_PASSB;
                mem_to_reg = MTR_IMM;
            end
            OP_AUIPC:  imm_sel = IMM_U;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm: multi-cycle RV32I controller with MIO_ready handshake, bus timeout, sticky fault and retire counter
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MIO_ready,
    input  logic [31:0]          inst_in,
    output logic [2:0]           ImmSel,
    output logic                 ALUSrc_B,
    output logic [3:0]           ALU_Control,
    output logic [1:0]           MemtoReg,
    output logic                 Branch,
    output logic                 BranchN,
    output logic [1:0]           Jump,
    output logic                 PC_write,
    output logic                 IR_write,
    output logic                 RegWrite,
    output logic                 CPU_MIO,
    output logic                 MemRW,
    output logic [2:0]           state_out,
    output logic                 fault,
    output logic [INSTRET_W-1:0] instret
);

    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    state_t        state, state_next;
    logic [WW-1:0] wait_cnt;
    logic          timeout, retire, flow;
    logic          dec_branch, dec_branch_n, illegal;
    logic [1:0]    dec_jump;
    iclass_t       iclass;

    mcpu_decode u_decode (
        .inst       (inst_in),
        .imm_sel    (ImmSel),
        .alu_src_b  (ALUSrc_B),
        .alu_ctrl   (ALU_Control),
        .mem_to_reg (MemtoReg),
        .branch     (dec_branch),
        .branch_n   (dec_branch_n),
        .jump       (dec_jump),
        .iclass     (iclass),
        .illegal    (illegal)
    );

    assign state_out = state;
    assign timeout   = wait_cnt == WW'(MEM_TIMEOUT - 1);
    assign flow      = iclass == CL_BRANCH || iclass == CL_JAL || iclass == CL_JALR;

    always_comb begin
        state_next = state;
        PC_write   = 1'b0;
        IR_write   = 1'b0;
        RegWrite   = 1'b0;
        CPU_MIO    = 1'b0;
        MemRW      = 1'b0;
        Branch     = 1'b0;
        BranchN    = 1'b0;
        Jump       = JMP_NONE;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                CPU_MIO    = 1'b1;
                IR_write   = MIO_ready;
                PC_write   = MIO_ready;
                state_next = MIO_ready ? DECODE : timeout ? TRAP : FETCH;
            end
            DECODE: state_next = illegal ? TRAP : EXEC;
            EXEC: begin
                Branch     = dec_branch;
                BranchN    = dec_branch_n;
                Jump       = dec_jump;
                PC_write   = flow;
                RegWrite   = iclass == CL_JAL || iclass == CL_JALR;
                retire     = flow;
                state_next = flow ? FETCH : (iclass == CL_LOAD || iclass == CL_STORE) ? MEM : WB;
            end
            MEM: begin
                CPU_MIO    = 1'b1;
                MemRW      = iclass == CL_STORE;
                retire     = MIO_ready && iclass == CL_STORE;
                state_next = MIO_ready ? (iclass == CL_STORE ? FETCH : WB) : timeout ? TRAP : MEM;
            end
            WB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            default: state_next = TRAP;
        endcase
        // Reset holds the state in FETCH, which would otherwise raise a request; keep the bus quiet.
        if (!rst) begin
            PC_write = 1'b0;
            IR_write = 1'b0;
            RegWrite = 1'b0;
            CPU_MIO  = 1'b0;
            MemRW    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
            fault    <= 1'b0;
            instret  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state_next == state && (state == FETCH || state == MEM)) ? wait_cnt + 1'b1 : '0;
            fault    <= fault | (state_next == TRAP);
            instret  <= instret + INSTRET_W'(retire);
        end
    end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// tb_mcpu_ctrl_fsm: vector table with a retire scoreboard plus hand sequences for traps and mid-MEM reset
module tb_mcpu_ctrl_fsm;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_TRAP = 3'd5;
    localparam logic [31:0] I_ADD = 32'h002081B3, I_LW = 32'h00802283;

    typedef struct {
        logic [31:0] ins;
        int          fw;
        int          mw;
        int          cyc;
        int          rw;
        int          pcw;
        int          irw;
        int          memw;
        logic [3:0]  alu;
        logic [1:0]  mtr;
        logic        br;
        logic        brn;
        logic [1:0]  jmp;
        logic [2:0]  imm;
        logic        srcb;
        int          ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MIO_ready = 1'b0;
    logic [31:0] inst_in = '0;
    logic [2:0]  ImmSel, state_out;
    logic        ALUSrc_B, Branch, BranchN, PC_write, IR_write, RegWrite, CPU_MIO, MemRW, fault;
    logic [3:0]  ALU_Control;
    logic [1:0]  MemtoReg, Jump;
    logic [31:0] instret;

    int          checks = 0;
    int          failures = 0;
    int unsigned model = 0;
    int unsigned exp_q[$];
    vec_t        vecs[17];
    int          n;

    mcpu_ctrl_fsm #(.MEM_TIMEOUT(16), .INSTRET_W(32)) dut (
        .clk(clk), .rst(rst), .MIO_ready(MIO_ready), .inst_in(inst_in),
        .ImmSel(ImmSel), .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control), .MemtoReg(MemtoReg),
        .Branch(Branch), .BranchN(BranchN), .Jump(Jump), .PC_write(PC_write), .IR_write(IR_write),
        .RegWrite(RegWrite), .CPU_MIO(CPU_MIO), .MemRW(MemRW), .state_out(state_out),
        .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r);
        @(negedge clk);
        MIO_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        MIO_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state_out), 32'(S_FETCH));
        chk("rst_mio", 32'(CPU_MIO), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_instret", instret, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        model = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t       o;
        int         fc, mc;
        logic [2:0] st;
        bit         done;
        o = v;
        o.cyc = 0; o.rw = 0; o.pcw = 0; o.irw = 0; o.memw = 0;
        o.alu = 'x; o.mtr = '0; o.br = 'x; o.brn = 'x; o.jmp = 'x; o.imm = 'x; o.srcb = 'x;
        fc = 0; mc = 0; done = 0;
        inst_in = v.ins;
        model += v.ret;
        exp_q.push_back(model);
        while (!done) begin
            @(negedge clk);
            st = state_out;
            MIO_ready = st == S_FETCH ? fc >= v.fw : st == S_MEM ? mc >= v.mw : 1'($urandom_range(0, 1));
            if (st == S_FETCH) fc++;
            if (st == S_MEM) mc++;
            #1;
            o.cyc++;
            o.rw   += int'(RegWrite);
            o.pcw  += int'(PC_write);
            o.irw  += int'(IR_write);
            o.memw += int'(CPU_MIO && MemRW);
            if (st == S_EXEC) begin
                o.alu = ALU_Control; o.br = Branch; o.brn = BranchN;
                o.jmp = Jump; o.imm = ImmSel; o.srcb = ALUSrc_B;
            end
            if (RegWrite) o.mtr = MemtoReg;
            @(posedge clk);
            #1;
            done = (st != S_FETCH && state_out == S_FETCH) || state_out == S_TRAP || o.cyc >= 64;
        end
        MIO_ready = 1'b0;
        chk($sformatf("v%0d_cycles", idx), o.cyc, v.cyc);
        chk($sformatf("v%0d_regwrite", idx), o.rw, v.rw);
        chk($sformatf("v%0d_pcwrite", idx), o.pcw, v.pcw);
        chk($sformatf("v%0d_irwrite", idx), o.irw, v.irw);
        chk($sformatf("v%0d_memwrite", idx), o.memw, v.memw);
        chk($sformatf("v%0d_alu", idx), 32'(o.alu), 32'(v.alu));
        chk($sformatf("v%0d_memtoreg", idx), 32'(o.mtr), 32'(v.mtr));
        chk($sformatf("v%0d_branch", idx), 32'({o.br, o.brn}), 32'({v.br, v.brn}));
        chk($sformatf("v%0d_jump", idx), 32'(o.jmp), 32'(v.jmp));
        chk($sformatf("v%0d_immsel", idx), 32'(o.imm), 32'(v.imm));
        chk($sformatf("v%0d_alusrcb", idx), 32'(o.srcb), 32'(v.srcb));
        chk($sformatf("v%0d_instret", idx), instret, exp_q.pop_front());
    endtask

    initial begin
        //          ins           fw  mw  cyc rw pcw irw memw alu   mtr br brn jmp imm srcb ret
        vecs[0]  = '{I_ADD,        0,  0,  4, 1, 1, 1, 0, 4'h0, 2'd0, 0, 0, 2'd0, 3'd0, 0, 1};
        vecs[1]  = '{32'h402081B3, 0,  0,  4, 1, 1, 1, 0, 4'h8, 2'd0, 0, 0, 2'd0, 3'd0, 0, 1};
        vecs[2]  = '{32'h00500093, 0,  0,  4, 1, 1, 1, 0, 4'h0, 2'd0, 0, 0, 2'd0, 3'd0, 1, 1};
        vecs[3]  = '{32'h4030D093, 0,  0,  4, 1, 1, 1, 0, 4'hD, 2'd0, 0, 0, 2'd0, 3'd0, 1, 1};
        vecs[4]  = '{32'h4000C093, 0,  0,  4, 1, 1, 1, 0, 4'h4, 2'd0, 0, 0, 2'd0, 3'd0, 1, 1};
        vecs[5]  = '{I_LW,         0,  3,  8, 1, 1, 1, 0, 4'h0, 2'd1, 0, 0, 2'd0, 3'd0, 1, 1};
        vecs[6]  = '{I_LW,         0, 15, 20, 1, 1, 1, 0, 4'h0, 2'd1, 0, 0, 2'd0, 3'd0, 1, 1};
        vecs[7]  = '{32'h00502223, 0,  0,  4, 0, 1, 1, 1, 4'h0, 2'd0, 0, 0, 2'd0, 3'd1, 1, 1};
        vecs[8]  = '{32'h00502223, 0,  2,  6, 0, 1, 1, 3, 4'h0, 2'd0, 0, 0, 2'd0, 3'd1, 1, 1};
        vecs[9]  = '{32'hFE000CE3, 0,  0,  3, 0, 2, 1, 0, 4'h8, 2'd0, 1, 0, 2'd0, 3'd2, 0, 1};
        vecs[10] = '{32'hFE001CE3, 0,  0,  3, 0, 2, 1, 0, 4'h8, 2'd0, 0, 1, 2'd0, 3'd2, 0, 1};
        vecs[11] = '{32'h008000EF, 0,  0,  3, 1, 2, 1, 0, 4'h0, 2'd2, 0, 0, 2'd1, 3'd4, 1, 1};
        vecs[12] = '{32'h000280E7, 0,  0,  3, 1, 2, 1, 0, 4'h0, 2'd2, 0, 0, 2'd2, 3'd0, 1, 1};
        vecs[13] = '{32'h123452B7, 0,  0,  4, 1, 1, 1, 0, 4'hF, 2'd3, 0, 0, 2'd0, 3'd3, 1, 1};
        vecs[14] = '{32'h00001297, 0,  0,  4, 1, 1, 1, 0, 4'h0, 2'd0, 0, 0, 2'd0, 3'd3, 1, 1};
        vecs[15] = '{I_ADD,        2,  0,  6, 1, 1, 1, 0, 4'h0, 2'd0, 0, 0, 2'd0, 3'd0, 0, 1};
        vecs[16] = '{I_ADD,       15,  0, 19, 1, 1, 1, 0, 4'h0, 2'd0, 0, 0, 2'd0, 3'd0, 0, 1};

        #1 rst = 1'b0;
        #1;
        chk("init_state", 32'(state_out), 32'(S_FETCH));
        chk("init_strobes", 32'({PC_write, IR_write, RegWrite, CPU_MIO, MemRW}), 0);
        chk("init_fault", 32'(fault), 0);
        chk("init_instret", instret, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Fetch timeout: 16 unanswered fetch cycles, then a sticky trap.
        do_reset();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0);
            if (state_out != S_FETCH) break;
            n++;
        end
        chk("fetch_timeout_cycles", n, 16);
        chk("fetch_timeout_state", 32'(state_out), 32'(S_TRAP));
        chk("fetch_timeout_fault", 32'(fault), 1);
        chk("fetch_timeout_mio", 32'(CPU_MIO), 0);
        repeat (3) step(1'b1);
        chk("trap_sticky_state", 32'(state_out), 32'(S_TRAP));
        chk("trap_sticky_strobes", 32'({PC_write, IR_write, RegWrite, CPU_MIO}), 0);
        chk("trap_sticky_fault", 32'(fault), 1);

        // Illegal opcode traps right after DECODE without retiring.
        do_reset();
        inst_in = 32'h0000007F;
        step(1'b1);
        step(1'b1);
        chk("illegal_decode", 32'(state_out), 32'(S_DECODE));
        step(1'b1);
        chk("illegal_state", 32'(state_out), 32'(S_TRAP));
        chk("illegal_fault", 32'(fault), 1);
        chk("illegal_mio", 32'(CPU_MIO), 0);
        chk("illegal_instret", instret, model);

        // Memory-phase timeout.
        do_reset();
        inst_in = I_LW;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0);
            if (state_out != S_MEM) break;
            n++;
        end
        chk("mem_timeout_cycles", n, 16);
        chk("mem_timeout_state", 32'(state_out), 32'(S_TRAP));
        chk("mem_timeout_fault", 32'(fault), 1);

        // Reset asserted while a load waits in MEM.
        do_reset();
        inst_in = I_LW;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        chk("midmem_state", 32'(state_out), 32'(S_MEM));
        chk("midmem_req", 32'({CPU_MIO, MemRW}), 32'(2'b10));
        step(1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midmem_rst_req", 32'({CPU_MIO, MemRW, RegWrite}), 0);
        chk("midmem_rst_state", 32'(state_out), 32'(S_FETCH));
        chk("midmem_rst_instret", instret, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        model = 0;
        run_vec(17, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
